// File: rtl/grc_pkg.sv
// rtl/grc_pkg.sv - shared state type, widths and saturating add for the game round controller
package grc_pkg;

  localparam int SCORE_W = 8;
  localparam int TIME_W  = 8;
  localparam int ID_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    COMMIT,
    DONE
  } grc_state_t;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0]         inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {{(SCORE_W-1){1'b0}}, inc};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/hoop_debounce.sv
// rtl/hoop_debounce.sv - 2-flop synchronizer plus level debouncer for the hoop switch
// rise_pulse is high for one cycle each time the debounced level goes 0->1.
module hoop_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic hoop_in,
  output logic rise_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic             level;
  logic [CNT_W-1:0] count;

  // count tracks how many consecutive samples have disagreed with the accepted level
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_0     <= 1'b0;
      sync_1     <= 1'b0;
      level      <= 1'b0;
      count      <= '0;
      rise_pulse <= 1'b0;
    end else begin
      sync_0     <= hoop_in;
      sync_1     <= sync_0;
      rise_pulse <= 1'b0;
      if (sync_1 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level      <= sync_1;
        count      <= '0;
        rise_pulse <= sync_1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - timed basketball round: scoring, countdown and leaderboard commit
// Define GRC_BONUS_EN to score 2 per basket while time_left <= 3.
module game_round_controller
  import grc_pkg::*;
#(
  parameter int TICK_CYCLES     = 50000000,
  parameter int ROUND_SECS      = 10,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              hoop_in,
  input  logic [ID_W-1:0]   user_id,
  input  logic              lb_ack,
  output logic [TIME_W-1:0] time_left,
  output logic [SCORE_W-1:0] score,
  output logic              round_active,
  output logic              lb_req,
  output logic [SCORE_W-1:0] lb_score,
  output logic [ID_W-1:0]   lb_id,
  output logic              game_over
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TIME_W-1:0] ROUND_TIME = TIME_W'(ROUND_SECS);
`ifdef GRC_BONUS_EN
  localparam logic [TIME_W-1:0] BONUS_SECS = TIME_W'(3);
`endif

  grc_state_t         state, state_n;
  logic [TICK_W-1:0]  tick_cnt, tick_n;
  logic [TIME_W-1:0]  time_n;
  logic [SCORE_W-1:0] score_n, lb_score_n;
  logic [ID_W-1:0]    id_q, id_n, lb_id_n;
  logic [1:0]         inc;
  logic               basket;

  hoop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hoop_debounce (
    .clock     (clock),
    .reset     (reset),
    .hoop_in   (hoop_in),
    .rise_pulse(basket)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      time_left <= ROUND_TIME;
      score     <= '0;
      id_q      <= '0;
      lb_score  <= '0;
      lb_id     <= '0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      time_left <= time_n;
      score     <= score_n;
      id_q      <= id_n;
      lb_score  <= lb_score_n;
      lb_id     <= lb_id_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    time_n     = time_left;
    score_n    = score;
    id_n       = id_q;
    lb_score_n = lb_score;
    lb_id_n    = lb_id;
`ifdef GRC_BONUS_EN
    inc = (time_left <= BONUS_SECS) ? 2'd2 : 2'd1;
`else
    inc = 2'd1;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = PLAY;
          tick_n  = '0;
          time_n  = ROUND_TIME;
          score_n = '0;
          id_n    = user_id;
        end
      end
      PLAY: begin
        if (basket) begin
          score_n = sat_add(score, inc);
        end
        // the cycle showing time_left==0 still scores; its result is what gets committed
        if (time_left == '0) begin
          state_n    = COMMIT;
          lb_score_n = score_n;
          lb_id_n    = id_q;
        end else if (tick_cnt == TICK_LAST) begin
          tick_n = '0;
          time_n = time_left - TIME_W'(1);
        end else begin
          tick_n = tick_cnt + TICK_W'(1);
        end
      end
      COMMIT: begin
        if (lb_ack) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign round_active = (state == PLAY);
  assign lb_req       = (state == COMMIT);
  assign game_over    = (state == DONE);

endmodule

// File: doc/game_round_controller.md
GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 SHALL have parameter TICK_CYCLES, 50000000, clock cycles per one-second tick.
REQ-002 SHALL have parameter ROUND_SECS, 10, round length in seconds (1..255).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, 250000, cycles hoop input must be stable before acceptance.
REQ-004 SHALL have port clock  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle round start request.
REQ-007 SHALL have port hoop_in  in  1  raw asynchronous hoop switch, 1 = ball present.
REQ-008 SHALL have port user_id  in  4  player ID, sampled at round start.
REQ-009 SHALL have port lb_ack  in  1  leaderboard accepted the committed entry.
REQ-010 SHALL have port time_left  out  8  seconds remaining.
REQ-011 SHALL have port score  out  8  current round score.
REQ-012 SHALL have port round_active  out  1  high in PLAY.
REQ-013 SHALL have port lb_req  out  1  leaderboard write request.
REQ-014 SHALL have port lb_score  out  8  score offered to the leaderboard.
REQ-015 SHALL have port lb_id  out  4  ID offered to the leaderboard.
REQ-016 SHALL have port game_over  out  1  high in DONE.

Function
REQ-017 SHALL implement FSM states IDLE, PLAY, COMMIT, DONE.
REQ-018 SHALL, on start in IDLE or DONE: next cycle PLAY, score=0, time_left=ROUND_SECS, tick counter=0, user_id latched.
REQ-019 SHALL ignore start in PLAY and COMMIT.
REQ-020 SHALL, in PLAY, decrement time_left once every TICK_CYCLES cycles; first decrement TICK_CYCLES cycles after PLAY entry.
REQ-021 SHALL enter COMMIT in the cycle after the decrement that makes time_left 0; time_left holds 0 until the next start.
REQ-022 SHALL pass hoop_in through a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-023 SHALL increment score by 1 on each debounced 0->1 edge while in PLAY, saturating at 255.
REQ-024 SHALL count an edge that coincides with the final tick cycle; edges outside PLAY SHALL be discarded.
REQ-025 SHALL, in COMMIT, assert lb_req with lb_score=score and lb_id=latched ID, held stable until lb_ack is sampled high.
REQ-026 SHALL deassert lb_req and enter DONE in the cycle after lb_ack; lb_ack outside COMMIT SHALL be ignored.
REQ-027 SHALL keep score and time_left displayed unchanged in COMMIT and DONE.

Reset
REQ-028 SHALL, while reset=0 at a clock edge: state IDLE, time_left=ROUND_SECS, score=0, lb_req=0, lb_score=0, lb_id=0, round_active=0, game_over=0, tick and debounce counters 0, debounced level 0.
REQ-029 SHALL abort any round on reset mid-PLAY or mid-COMMIT with no leaderboard request issued after reset.

Configuration
REQ-030 SHALL, with GRC_BONUS_EN defined, add 2 per basket while time_left<=3 (still saturating at 255).
REQ-031 SHALL, without GRC_BONUS_EN, add 1 per basket at all times.

Structure
REQ-032 SHALL take the state enum, SCORE_W=8, TIME_W=8 and ID_W=4 from shared package grc_pkg.
REQ-033 SHALL place synchronizer and debouncer in sub-module hoop_debounce (output: one-cycle rising-edge pulse).

Verification (TICK_CYCLES=10, ROUND_SECS=3, DEBOUNCE_CYCLES=4)
REQ-034 SHALL check: reset then start pulse -> round_active=1 next cycle, time_left 3->2->1->0 at 10-cycle intervals, lb_req the cycle after reaching 0.
REQ-035 SHALL check: three clean hoop pulses of 8 cycles high in PLAY -> score=3, lb_score=3, lb_id=latched user_id.
REQ-036 SHALL check: hoop glitch of 2 cycles high -> score unchanged; basket with time_left=1 and GRC_BONUS_EN -> +2.
REQ-037 SHALL check: lb_ack held 0 for 20 cycles -> lb_req and lb_score stable; lb_ack=1 -> lb_req=0 and game_over=1 next cycle.
REQ-038 SHALL check: start during PLAY -> ignored; reset=0 mid-PLAY -> IDLE, score=0, time_left=3, no lb_req.
REQ-039 SHALL check: 260 baskets in PLAY (long round) -> score saturates at 255.
